// File: rtl/clk_ratio_meter_pkg.sv
// Shared definitions for the clock ratio meter: FSM state encoding,
// default counter width and the counter saturation value.
package clk_ratio_meter_pkg;

    // Measurement FSM states; the encoding is visible to status readers.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } meas_state_t;

    // Default width of the period and high-time counters.
    localparam int CNT_WIDTH_DEF = 8;

    // Width of the consecutive-match counter; holds lock counts up to 15.
    localparam int MATCH_WIDTH = 4;

    // Largest value a counter of the given width can hold. Measurements
    // saturate here and a missing edge is declared at this count.
    function automatic int unsigned max_cnt(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for a single asynchronous input, followed by a
// history flop that turns the synchronized level into a one-cycle rising
// edge pulse. Usable for any slow asynchronous level or clock.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the asynchronous input through the synchronizer chain and keep
    // one cycle of history of the synchronized level for edge detection.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the
            // previous stage's old value, giving a true shift register;
            // blocking assignments here would collapse the chain.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/clk_ratio_meter.sv
// Measures the period and high time of a slow asynchronous clock in units
// of i_ref_clk cycles. A stable period report recovers the divide ratio of
// the clock divider it monitors; o_locked indicates the ratio has settled
// and o_timeout flags a stopped clock.
module clk_ratio_meter
    import clk_ratio_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int LOCK_COUNT  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rstn,
    input  logic                 i_meas_clk,
    input  logic                 i_meas_en,
    output logic [CNT_WIDTH-1:0] o_ratio,
    output logic [CNT_WIDTH-1:0] o_high_cnt,
    output logic                 o_valid,
    output logic                 o_locked,
    output logic                 o_timeout
);

    localparam logic [CNT_WIDTH-1:0]   MAX_CNT   = CNT_WIDTH'(max_cnt(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [MATCH_WIDTH-1:0] MATCH_ONE = MATCH_WIDTH'(1);
    localparam logic [MATCH_WIDTH-1:0] LOCK_CNT  = MATCH_WIDTH'(LOCK_COUNT);

    logic                   w_level;
    logic                   w_rise;
    logic                   w_same_period;
    logic [MATCH_WIDTH-1:0] w_match_next;

    meas_state_t            r_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   r_hcnt;
    logic [CNT_WIDTH-1:0]   r_ratio;
    logic [CNT_WIDTH-1:0]   r_high_cnt;
    logic [MATCH_WIDTH-1:0] r_match;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_timeout;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .i_clk   (i_ref_clk),
        .i_rstn  (i_rstn),
        .i_async (i_meas_clk),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    // Lock comparator: a non-zero match count means a previous measurement
    // exists, so the period just counted can be compared with it.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // condition so no path leaves it unassigned and infers a latch.
        w_same_period = 1'b0;
        w_match_next  = MATCH_ONE;
        if ((r_match != '0) && (r_cnt == r_ratio)) begin
            w_same_period = 1'b1;
        end
        if (w_same_period) begin
            w_match_next = (r_match >= LOCK_CNT) ? LOCK_CNT : (r_match + MATCH_ONE);
        end
    end

    // Measurement FSM with its counters and registered status outputs.
    always_ff @(posedge i_ref_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_ratio    <= '0;
            r_high_cnt <= '0;
            r_match    <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            // Pulse outputs default low; the branches below raise them.
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            if (!i_meas_en) begin
                // Disabling discards any measurement in flight but keeps
                // the last reported period and high time readable.
                r_state  <= ST_IDLE;
                r_cnt    <= '0;
                r_hcnt   <= '0;
                r_match  <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                    end
                    ST_ARM: begin
                        // The first edge only marks the start of a period.
                        if (w_rise) begin
                            r_cnt   <= CNT_ONE;
                            r_hcnt  <= CNT_ONE;
                            r_state <= ST_MEASURE;
                        end
                    end
                    ST_MEASURE: begin
                        if (w_rise) begin
                            // An edge on the last count still reports, so
                            // a period of exactly MAX_CNT is measurable.
                            r_ratio    <= r_cnt;
                            r_high_cnt <= r_hcnt;
                            r_valid    <= 1'b1;
                            r_match    <= w_match_next;
                            r_locked   <= (w_match_next == LOCK_CNT);
                            r_cnt      <= CNT_ONE;
                            r_hcnt     <= CNT_ONE;
                        end else if (r_cnt == MAX_CNT) begin
                            // The clock stopped: report it once and re-arm
                            // instead of letting the counters wrap.
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                            r_match   <= '0;
                            r_cnt     <= '0;
                            r_hcnt    <= '0;
                            r_state   <= ST_ARM;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                            if (w_level) begin
                                r_hcnt <= r_hcnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ratio    = r_ratio;
    assign o_high_cnt = r_high_cnt;
    assign o_valid    = r_valid;
    assign o_locked   = r_locked;
    assign o_timeout  = r_timeout;

endmodule

// File: doc/clk_ratio_meter.md
Name: clk_ratio_meter

Overview:
Measures an asynchronous, slower clock (typically a CLK_DIV-generated clock) against i_ref_clk. Reports its period and high time in ref-clock cycles, which recovers the programmed divide ratio. Sits beside the clock divider as a self-check and monitor, feeding status to the register file.

Parameters:
CNT_WIDTH, 8, width of the period and high-time counters and outputs; MAX_CNT = 2^CNT_WIDTH-1.
LOCK_COUNT, 2, number of consecutive identical period measurements required to assert o_locked (range 2..15).
SYNC_STAGES, 2, flip-flop stages in the i_meas_clk synchronizer (minimum 2).

Ports:
i_ref_clk  in  1  reference clock; all logic in this domain
i_rstn  in  1  asynchronous active-low reset
i_meas_clk  in  1  clock under measurement, asynchronous to i_ref_clk, sampled as data
i_meas_en  in  1  measurement enable; level-sensitive
o_ratio  out  CNT_WIDTH  last measured period in ref cycles
o_high_cnt  out  CNT_WIDTH  last measured high time in ref cycles
o_valid  out  1  one-cycle pulse when o_ratio and o_high_cnt update
o_locked  out  1  LOCK_COUNT consecutive equal periods seen
o_timeout  out  1  one-cycle pulse when no edge arrives within MAX_CNT cycles

Behaviour:
- Interface decision: reset i_rstn, asynchronous, active-low; clock i_ref_clk.
- Reset: all outputs 0, FSM in IDLE, counters 0, synchronizer flops 0.
- Synchronizer: SYNC_STAGES flops plus one history flop. s = last sync stage. rise = s & ~s_d.
- Supported measured periods are 2..MAX_CNT ref cycles. The measured clock must be synchronous-ratio or slower than i_ref_clk/2.
- FSM states: IDLE, ARM, MEASURE.
- IDLE: entered whenever i_meas_en=0, from any state, on the next cycle.
  - Counters and match count are cleared.
  - o_locked=0, o_valid=0.
  - o_ratio and o_high_cnt hold their values.
  - IDLE -> ARM when i_meas_en=1.
- ARM: waits for rise; there is no timeout in ARM.
  - On rise: cnt<=1, hcnt<=1, -> MEASURE.
- MEASURE, every cycle without rise:
  - cnt<=cnt+1.
  - hcnt<=hcnt+1 if s=1.
- MEASURE, on rise:
  - o_ratio<=cnt and o_high_cnt<=hcnt, with o_valid=1 in the following cycle (registered).
  - cnt<=1, hcnt<=1, stay in MEASURE.
- Counting definition: cnt includes the rise cycle. For a clock with period N, o_ratio=N and o_high_cnt = high cycles. A CLK_DIV clock with ratio R therefore gives o_ratio=R and o_high_cnt=R>>1.
- First measurement: the first rise only arms the block. The first o_valid follows the second rise. Latency from a meas-clock edge to o_valid is SYNC_STAGES+2 ref cycles.
- Lock tracking:
  - On each measurement, if cnt equals the previous o_ratio and a previous measurement exists, match count is incremented, saturating at LOCK_COUNT. Otherwise match count<=1.
  - o_locked=1 when match count reaches LOCK_COUNT. It updates in the same cycle as o_valid.
  - A mismatch clears o_locked in the same cycle as o_valid.
- Timeout: in MEASURE, when cnt==MAX_CNT and there is no rise:
  - o_timeout pulses for 1 cycle.
  - o_locked<=0, match count<=0, -> ARM.
  - o_ratio holds.
- Simultaneous rise with cnt==MAX_CNT: rise wins; the block reports MAX_CNT with no timeout.
- Counters never wrap.
- i_meas_en deassert mid-measurement: the measurement is discarded, with no o_valid and no o_timeout.
- Asynchronous reset mid-operation returns the block to the reset state immediately. The first post-reset measurement needs two rises.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, ARM=1, MEASURE=2), CNT_WIDTH default, and the MAX_CNT derivation.
- Sub-module: sync_edge_det holds the SYNC_STAGES synchronizer, the history flop and the rise output, and is reusable for other async inputs.
- Remaining logic stays in the top module: FSM, counters and lock comparator.

Test Plan:
- Drive i_meas_clk from CLK_DIV with ratio 4 and i_meas_en=1 -> after the second rise: o_valid pulses, o_ratio=4, o_high_cnt=2. The next o_valid asserts o_locked=1 (LOCK_COUNT=2).
- Ratios 2, 5 and 255 -> o_ratio=2/5/255, o_high_cnt=1/2/127. No o_timeout at 255.
- Switch from ratio 6 to 8 while locked -> the first differing measurement gives o_ratio=8, o_locked=0. The next 8 gives o_locked=1.
- Hold i_meas_clk low after lock -> o_timeout pulses once, 255 cycles after the last counted rise. Then o_locked=0, state ARM, o_ratio still 8, and no further timeouts.
- Deassert i_meas_en mid-period for 3 cycles, then reassert -> no o_valid while disabled, o_locked=0, o_ratio holds. The first new o_valid arrives only after two rises.
- Assert i_rstn=0 mid-measurement -> all outputs are 0 immediately. After release, behaviour matches the first scenario.
